dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// ------------
// Shares one single-port data memory between the pipeline MEM stage (CPU)
// and an external loader (host). The CPU has priority, but a pending host
// request is only made to yield for HOST_MAX_WAIT cycles before it is
// forced through, stalling the CPU for that one cycle. Each host access is
// followed by an ACK cycle in which the host cannot be granted, so the host
// issues at most one access every two cycles.
//
// Optional feature: define DMEM_ARB_STATS_EN to enable the saturating
// stall_cnt / host_cnt statistics counters. Without it both outputs are
// tied to zero and no counter flops exist.
//
// Ports
//   clk                     sole clock, rising edge
//   reset                   asynchronous, active-low reset
//   cpu_req, cpu_we         MEM-stage access request and write flag
//   cpu_addr, cpu_wdata     CPU address and store data
//   cpu_rdata               load data (combinational from mem_rdata)
//   cpu_stall               holds the MEM stage and all earlier stages
//   host_req, host_we       loader request and write flag
//   host_addr, host_wdata   loader address and write data
//   host_rdata              read data captured on the host grant edge
//   host_ack                one-cycle completion pulse (the ACK cycle)
//   mem_we, mem_addr,
//   mem_wdata, mem_rdata    single-port memory, combinational read,
//                           write on clk rising edge
//   stall_cnt, host_cnt     statistics counters

module dmem_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 32,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       host_cnt
);

    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        wait_cnt_reg;
    logic [3:0]        wait_cnt_next;
    logic              host_ack_reg;
    logic [DATA_W-1:0] host_rdata_reg;

    logic              host_grant;
    logic              cpu_grant;

    // ------------------------------------------------------------------
    // Arbitration FSM: next state, grants and the host wait counter
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        host_grant    = 1'b0;
        cpu_grant     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Host wins when the CPU is quiet, or once it has yielded
                // for the full HOST_MAX_WAIT cycles.
                host_grant = host_req & (~cpu_req | (wait_cnt_reg == MAX_WAIT));
                cpu_grant  = cpu_req & ~host_grant;

                if (host_grant) begin
                    state_next = ACK;
                end

                if (~host_req || host_grant) begin
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt_reg < MAX_WAIT) begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end

            ACK: begin
                // The host is never granted here; a host_req still high is
                // a fresh transaction that competes in the next IDLE cycle.
                cpu_grant  = cpu_req;
                state_next = IDLE;
                if (~host_req) begin
                    wait_cnt_next = 4'd0;
                end
            end

            default: begin
                state_next    = IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port mux. With no grant the CPU side still drives the address
    // and data so the combinational read path stays on the CPU address.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & cpu_grant;
        if (host_grant) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_req & host_grant;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= 4'd0;
            host_ack_reg   <= 1'b0;
            host_rdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            // The ack pulse is exactly the ACK cycle that follows a grant.
            host_ack_reg <= host_grant;
            // Capture on every grant, writes included (returns the word as
            // it was before the write lands).
            if (host_grant) begin
                host_rdata_reg <= mem_rdata;
            end
        end
    end

    assign host_ack   = host_ack_reg;
    assign host_rdata = host_rdata_reg;

    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] host_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= 16'd0;
            host_cnt_reg  <= 16'd0;
        end else begin
            if (cpu_stall && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (host_grant && (host_cnt_reg != 16'hFFFF)) begin
                host_cnt_reg <= host_cnt_reg + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign host_cnt  = host_cnt_reg;
`else
    assign stall_cnt = 16'd0;
    assign host_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// ---------------
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Expected host read data is pushed to a queue when a host access is
// granted and popped when host_ack shows up. Outputs are sampled on the
// falling edge or 1 time unit after the rising edge.

module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stall_cnt, host_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .HOST_MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stall_cnt  (stall_cnt),
        .host_cnt   (host_cnt)
    );

    // Behavioural memory: 256 words, unwritten words read a fixed pattern.
    function automatic logic [31:0] pattern(input logic [7:0] idx);
        return 32'h1000_0000 + {24'd0, idx};
    endfunction

    bit          wr_flag [0:255];
    logic [31:0] mem_arr [0:255];
    logic [7:0]  mem_idx;

    assign mem_idx   = mem_addr[9:2];
    assign mem_rdata = wr_flag[mem_idx] ? mem_arr[mem_idx] : pattern(mem_idx);

    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_idx] <= mem_wdata;
            wr_flag[mem_idx] <= 1'b1;
        end
    end

    // Scoreboard and reference state
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model_mem [0:255];
    int          model_stall  = 0;
    int          model_hgrant = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] stats_exp(input int v);
`ifdef DMEM_ARB_STATS_EN
        return 32'(v);
`else
        return 32'(v & 0);
`endif
    endfunction

    function automatic logic [7:0] widx(input logic [31:0] a);
        return a[9:2];
    endfunction

    // One host transaction with the CPU left as it is; waits (bounded) for
    // host_ack, then compares host_rdata against the scoreboard.
    task automatic host_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bit          got;
        logic [31:0] e;
        got = 1'b0;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        exp_q.push_back(model_mem[widx(addr)]);
        if (we) model_mem[widx(addr)] = wd;
        model_hgrant++;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (host_ack) got = 1'b1;
        end
        host_req = 1'b0; host_we = 1'b0;
        check("host_ack_seen", {31'd0, got}, 32'd1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("host_rdata", host_rdata, e);
        end
        $display("host txn we=%0d addr=%h wdata=%h -> rdata=%h", we, addr, wd, host_rdata);
    endtask

    initial begin
        logic [31:0] e;
        bit          exp_grant, exp_ack;

        for (int i = 0; i < 256; i++) model_mem[i] = pattern(8'(i));

        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_host_ack",   {31'd0, host_ack},  32'd0);
        check("rst_host_rdata", host_rdata,          32'd0);
        check("rst_cpu_stall",  {31'd0, cpu_stall}, 32'd0);
        check("rst_mem_we",     {31'd0, mem_we},    32'd0);
        check("rst_stall_cnt",  {16'd0, stall_cnt}, 32'd0);
        check("rst_host_cnt",   {16'd0, host_cnt},  32'd0);
        $display("reset: host_ack=%0d host_rdata=%h cpu_stall=%0d mem_we=%0d", host_ack, host_rdata, cpu_stall, mem_we);

        // CPU write while still in reset: the CPU path stays live.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0BAD_0001;
        #1;
        check("rst_cpu_mem_we", {31'd0, mem_we},    32'd1);
        check("rst_cpu_stall2", {31'd0, cpu_stall}, 32'd0);
        model_mem[0] = 32'h0BAD_0001;
        $display("reset cpu write addr=%h mem_we=%0d", cpu_addr, mem_we);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        reset = 1'b1;

        // ---- Host write 0x40, CPU idle ----
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h40; host_wdata = 32'hDEAD_BEEF;
        exp_q.push_back(model_mem[8'h10]);
        model_mem[8'h10] = 32'hDEAD_BEEF;
        model_hgrant++;
        @(negedge clk);
        check("hw_mem_we",    {31'd0, mem_we},    32'd1);
        check("hw_mem_addr",  mem_addr,           32'h40);
        check("hw_mem_wdata", mem_wdata,          32'hDEAD_BEEF);
        check("hw_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("hw_ack_early", {31'd0, host_ack},  32'd0);
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
        check("hw_ack", {31'd0, host_ack}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hw_rdata", host_rdata, e);
        end
        $display("host write addr=40 wdata=deadbeef ack=%0d rdata=%h", host_ack, host_rdata);
        @(posedge clk); #1;
        check("hw_ack_pulse", {31'd0, host_ack}, 32'd0);

        // ---- Host read back ----
        host_txn(1'b0, 32'h40, 32'h0);

        // ---- CPU read / write, host idle ----
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        @(negedge clk);
        check("cr_rdata", cpu_rdata,          model_mem[8'h11]);
        check("cr_stall", {31'd0, cpu_stall}, 32'd0);
        check("cr_we",    {31'd0, mem_we},    32'd0);
        $display("cpu read addr=44 rdata=%h", cpu_rdata);
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 32'h48; cpu_wdata = 32'h5A5A_1234;
        @(negedge clk);
        check("cw_we",    {31'd0, mem_we}, 32'd1);
        check("cw_wdata", mem_wdata,       32'h5A5A_1234);
        model_mem[8'h12] = 32'h5A5A_1234;
        $display("cpu write addr=48 wdata=%h", mem_wdata);
        @(posedge clk); #1;
        cpu_we = 1'b0;
        @(negedge clk);
        check("cw_readback", cpu_rdata, 32'h5A5A_1234);
        $display("cpu read addr=48 rdata=%h", cpu_rdata);

        // ---- Simultaneous requests, then host starvation bound ----
        @(posedge clk); #1;
        cpu_addr = 32'h44;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
        for (int c = 1; c <= 12; c++) begin
            exp_grant = (c == 5) || (c == 11);
            exp_ack   = (c == 6) || (c == 12);
            @(negedge clk);
            check($sformatf("sv_stall_c%0d", c), {31'd0, cpu_stall}, {31'd0, exp_grant});
            check($sformatf("sv_ack_c%0d", c),   {31'd0, host_ack},  {31'd0, exp_ack});
            if (exp_grant) begin
                check($sformatf("sv_addr_c%0d", c), mem_addr, 32'h40);
                exp_q.push_back(model_mem[8'h10]);
                model_stall++;
                model_hgrant++;
            end else begin
                check($sformatf("sv_cpu_rdata_c%0d", c), cpu_rdata, model_mem[8'h11]);
            end
            if (host_ack && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("sv_host_rdata_c%0d", c), host_rdata, e);
            end
            if (c == 10) begin
                check("stats_stall", {16'd0, stall_cnt}, stats_exp(model_stall));
                check("stats_host",  {16'd0, host_cnt},  stats_exp(model_hgrant));
            end
            $display("cycle %0d: cpu_stall=%0d host_ack=%0d mem_addr=%h", c, cpu_stall, host_ack, mem_addr);
            @(posedge clk); #1;
            if (c == 1) begin
                check("sim_wait_cnt", {28'd0, dut.wait_cnt_reg}, 32'd1);
            end
            if (c == 11) begin
                host_req = 1'b0;
            end
        end
        cpu_req = 1'b0;

        // ---- Reset during ACK ----
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h80; host_wdata = 32'hCAFE_F00D;
        model_mem[8'h20] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        host_req = 1'b0; host_we = 1'b0;
        check("ra_ack_before", {31'd0, host_ack}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("ra_ack_lost", {31'd0, host_ack},                32'd0);
        check("ra_rdata",    host_rdata,                        32'd0);
        check("ra_fsm_idle", {31'd0, 1'(dut.state_reg)},       32'd0);
        $display("reset in ACK: host_ack=%0d state=%0d", host_ack, dut.state_reg);
        @(posedge clk); #1;
        reset = 1'b1;
        model_stall  = 0;
        model_hgrant = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        @(negedge clk);
        check("ra_committed", cpu_rdata, 32'hCAFE_F00D);
        $display("cpu read addr=80 after reset rdata=%h", cpu_rdata);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // Host reissues the transaction whose ack was lost.
        host_txn(1'b0, 32'h80, 32'h0);
        @(negedge clk);
        check("final_stall_cnt", {16'd0, stall_cnt}, stats_exp(model_stall));
        check("final_host_cnt",  {16'd0, host_cnt},  stats_exp(model_hgrant));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
